// File: rtl/instr_fetch.sv
// instr_fetch: MIPS program counter sequencer and instruction fetch unit.
// Latency: one instruction per FETCH+EXEC pair, so L+2 cycles for an ack latency of L.
// Backpressure: waits in FETCH until imem_ack. Holds in EXEC while stall is high.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   imem_req/addr/ack/rdata   instruction memory request/response (addr == pc)
//   instr, op                 instruction register and its opcode field
//   pc, pc_plus4              current instruction address and pc + 4
//   instr_valid               instr is executing this cycle (EXEC state)
//   stall                     holds the current instruction in EXEC
//   Jump, Branch, zero        decoder/ALU inputs that select the next PC
//   instr_count               retired-instruction counter (wraps)
module instr_fetch #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   input  logic        stall,
   input  logic        Jump,
   input  logic        Branch,
   input  logic        zero,
   output logic [31:0] instr_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } state_t;

   // Word alignment is enforced on the reset vector itself.
   localparam logic [31:0] PC_INIT = {PC_RESET[31:2], 2'b00};

   state_t      state;
   state_t      stateNext;
   logic [31:0] pcReg;
   logic [31:0] instrReg;
   logic [31:0] countReg;
   logic [31:0] pcPlus4;
   logic [31:0] branchOffset;
   logic [31:0] nextPc;
   logic        reqRaw;
   logic        validRaw;
   logic        captureInstr;
   logic        retire;

   assign pcPlus4      = pcReg + 32'd4;
   assign branchOffset = {{14{instrReg[15]}}, instrReg[15:0], 2'b00};

   assign pc          = pcReg;
   assign pc_plus4    = pcPlus4;
   assign imem_addr   = pcReg;
   assign instr       = instrReg;
   assign instr_count = countReg;

   // Reset masks the handshake outputs in the reset cycle itself, so a
   // request in flight is visibly dropped before the state register clears.
   assign imem_req    = reqRaw & ~rst;
   assign instr_valid = validRaw & ~rst;
   assign op          = rst ? 6'd0 : instrReg[5'd31 -: 6];

   // Next PC: jump beats a taken branch; everything wraps modulo 2^32.
   always_comb begin
      nextPc = pcPlus4;
      if (Jump) begin
         nextPc = {pcPlus4[31:28], instrReg[25:0], 2'b00};
      end else if (Branch && zero) begin
         nextPc = pcPlus4 + branchOffset;
      end
   end

   always_comb begin
      stateNext    = state;
      reqRaw       = 1'b0;
      validRaw     = 1'b0;
      captureInstr = 1'b0;
      retire       = 1'b0;
      case (state)
         IDLE: begin
            stateNext = FETCH;
         end
         FETCH: begin
            reqRaw = 1'b1;
            if (imem_ack) begin
               captureInstr = 1'b1;
               stateNext    = EXEC;
            end
         end
         EXEC: begin
            validRaw = 1'b1;
            if (!stall) begin
               retire    = 1'b1;
               stateNext = FETCH;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pcReg    <= PC_INIT;
         instrReg <= 32'd0;
         countReg <= 32'd0;
      end else begin
         state <= stateNext;
         if (captureInstr) begin
            instrReg <= imem_rdata;
         end
         if (retire) begin
            pcReg    <= nextPc;
            countReg <= countReg + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized self-checking bench for instr_fetch.
// Latency: the bench acts as instruction memory with a chosen ack latency per fetch.
// Backpressure: stall cycles and ack delays come from the scenario tasks or $urandom.
module tb_instr_fetch;

   localparam logic [31:0] RST_PC  = 32'h4000_0000;  // from PC_RESET 32'h4000_0001
   localparam logic [31:0] RST_PCW = 32'hFFFF_FFF8;  // from PC_RESET 32'hFFFF_FFFB

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        stall = 1'b0;
   logic        Jump = 1'b0;
   logic        Branch = 1'b0;
   logic        zero = 1'b0;

   logic        imem_req, instr_valid;
   logic [31:0] imem_addr, instr, pc, pc_plus4, instr_count;
   logic [5:0]  op;

   // Second instance, reset near the top of the address space, shares every
   // input so its handshake timing matches; only its addresses differ.
   logic        wReq, wValid;
   logic [31:0] wAddr, wInstr, wPc, wPcPlus4, wCount;
   logic [5:0]  wOp;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] expPc, expPcW, expCount;

   always #5 clk = ~clk;

   instr_fetch #(.PC_RESET(32'h4000_0001)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .op(op),
      .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid), .stall(stall),
      .Jump(Jump), .Branch(Branch), .zero(zero), .instr_count(instr_count)
   );

   instr_fetch #(.PC_RESET(32'hFFFF_FFFB)) dutWrap (
      .clk(clk), .rst(rst), .imem_req(wReq), .imem_addr(wAddr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(wInstr), .op(wOp),
      .pc(wPc), .pc_plus4(wPcPlus4), .instr_valid(wValid), .stall(stall),
      .Jump(Jump), .Branch(Branch), .zero(zero), .instr_count(wCount)
   );

   // Reference next-PC rule, written as plain address arithmetic.
   function automatic logic [31:0] refNextPc(input logic [31:0] p, input logic [31:0] w,
                                             input logic j, input logic b, input logic z);
      logic [31:0] seq;
      int          off;
      seq = p + 32'd4;
      if (j) return (seq & 32'hF000_0000) | ({6'd0, w[25:0]} * 32'd4);
      if (b && z) begin
         off = int'($signed(w[15:0]));
         return seq + 32'(off * 4);
      end
      return seq;
   endfunction

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Runs one instruction from its first FETCH cycle to the next FETCH cycle.
   task automatic do_instr(input int lat, input logic [31:0] data, input int stalls,
                           input logic j, input logic b, input logic z);
      for (int k = 0; k <= lat; k++) begin
         vectors++;
         if ({imem_req, instr_valid, imem_addr, pc, pc_plus4} !== {1'b1, 1'b0, expPc, expPc, expPc + 32'd4}) begin
            miscompares++;
            $display("FAIL fetch_state got req=%b vld=%b addr=%h pc=%h pc4=%h exp addr=%h", imem_req, instr_valid, imem_addr, pc, pc_plus4, expPc);
         end
         vectors++;
         if ({wReq, wAddr, wPcPlus4} !== {1'b1, expPcW, expPcW + 32'd4}) begin
            miscompares++;
            $display("FAIL wrap_fetch got req=%b addr=%h pc4=%h exp addr=%h", wReq, wAddr, wPcPlus4, expPcW);
         end
         imem_ack   = (k == lat);
         imem_rdata = (k == lat) ? data : $urandom;
         stall      = 1'($urandom);
         Jump       = 1'($urandom);
         Branch     = 1'($urandom);
         zero       = 1'($urandom);
         cycle();
      end
      for (int s = 0; s <= stalls; s++) begin
         vectors++;
         if ({instr_valid, imem_req, instr, op, pc, instr_count} !== {1'b1, 1'b0, data, data[31:26], expPc, expCount}) begin
            miscompares++;
            $display("FAIL exec_state got vld=%b req=%b instr=%h op=%h pc=%h cnt=%0d exp instr=%h pc=%h cnt=%0d", instr_valid, imem_req, instr, op, pc, instr_count, data, expPc, expCount);
         end
         vectors++;
         if ({wValid, wPc, wCount, wInstr} !== {1'b1, expPcW, expCount, data}) begin
            miscompares++;
            $display("FAIL wrap_exec got vld=%b pc=%h cnt=%0d exp pc=%h cnt=%0d", wValid, wPc, wCount, expPcW, expCount);
         end
         stall      = (s < stalls);
         imem_ack   = 1'($urandom);
         imem_rdata = $urandom;
         Jump       = (s < stalls) ? 1'($urandom) : j;
         Branch     = (s < stalls) ? 1'($urandom) : b;
         zero       = (s < stalls) ? 1'($urandom) : z;
         cycle();
      end
      imem_ack = 1'b0;
      expPc    = refNextPc(expPc, data, j, b, z);
      expPcW   = refNextPc(expPcW, data, j, b, z);
      expCount = expCount + 32'd1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cycle();
      vectors++;
      if ({imem_req, instr_valid, op, instr, pc, pc_plus4, instr_count} !== {1'b0, 1'b0, 6'd0, 32'd0, RST_PC, RST_PC + 32'd4, 32'd0}) begin
         miscompares++;
         $display("FAIL reset_state got req=%b vld=%b op=%h instr=%h pc=%h pc4=%h cnt=%0d", imem_req, instr_valid, op, instr, pc, pc_plus4, instr_count);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if ({imem_req, instr_valid, wPc} !== {1'b0, 1'b0, RST_PCW}) begin
         miscompares++;
         $display("FAIL reset_idle got req=%b vld=%b wpc=%h exp 0 0 %h", imem_req, instr_valid, wPc, RST_PCW);
      end
      cycle();
      expPc    = RST_PC;
      expPcW   = RST_PCW;
      expCount = 32'd0;
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 4; i++) do_instr(0, $urandom, 0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if ({instr_count, imem_addr, wAddr} !== {32'd4, RST_PC + 32'h10, 32'h0000_0008}) begin
         miscompares++;
         $display("FAIL seq_after4 got cnt=%0d addr=%h waddr=%h exp 4 %h 00000008", instr_count, imem_addr, wAddr, RST_PC + 32'h10);
      end
   endtask

   task automatic test_latency();
      do_instr(3, $urandom, 0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (imem_addr !== RST_PC + 32'h14) begin
         miscompares++;
         $display("FAIL latency_next got %h exp %h", imem_addr, RST_PC + 32'h14);
      end
   endtask

   task automatic test_branch();
      logic [31:0] beq;
      beq = {6'h04, 5'd1, 5'd2, 16'hFFFE};
      do_instr(0, {6'h02, 26'h8}, 0, 1'b1, 1'b0, 1'b0);
      do_instr(1, beq, 0, 1'b0, 1'b1, 1'b1);
      vectors++;
      if (imem_addr !== RST_PC + 32'h1C) begin
         miscompares++;
         $display("FAIL beq_taken got %h exp %h", imem_addr, RST_PC + 32'h1C);
      end
      do_instr(0, {6'h02, 26'h8}, 0, 1'b1, 1'b0, 1'b0);
      do_instr(0, beq, 0, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (imem_addr !== RST_PC + 32'h24) begin
         miscompares++;
         $display("FAIL beq_not_taken got %h exp %h", imem_addr, RST_PC + 32'h24);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] w;
      // Reset while in EXEC with a jump pending.
      w = $urandom;
      imem_ack = 1'b1; imem_rdata = w; stall = 1'b0;
      cycle();
      rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; Jump = 1'b1; Branch = 1'b1; zero = 1'b1;
      #1;
      vectors++;
      if ({imem_req, instr_valid, op} !== {1'b0, 1'b0, 6'd0}) begin
         miscompares++;
         $display("FAIL rst_exec_during got req=%b vld=%b op=%h exp 0 0 00", imem_req, instr_valid, op);
      end
      cycle();
      rst = 1'b0; Jump = 1'b0; Branch = 1'b0;
      #1;
      vectors++;
      if ({imem_req, instr_valid, instr, pc, instr_count, wPc} !== {1'b0, 1'b0, 32'd0, RST_PC, 32'd0, RST_PCW}) begin
         miscompares++;
         $display("FAIL rst_exec_after got req=%b vld=%b instr=%h pc=%h cnt=%0d wpc=%h", imem_req, instr_valid, instr, pc, instr_count, wPc);
      end
      cycle();
      expPc = RST_PC; expPcW = RST_PCW; expCount = 32'd0;
      do_instr(0, $urandom, 0, 1'b0, 1'b0, 1'b0);
      // Reset in the middle of a 3-cycle ack wait; the ack lands in the reset cycle.
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if ({imem_req, imem_addr} !== {1'b1, expPc}) begin
            miscompares++;
            $display("FAIL rst_fetch_wait got req=%b addr=%h exp 1 %h", imem_req, imem_addr, expPc);
         end
         imem_ack = 1'b0;
         cycle();
      end
      rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      #1;
      vectors++;
      if (imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_fetch_req got %b exp 0", imem_req);
      end
      cycle();
      rst = 1'b0; imem_ack = 1'b0;
      #1;
      vectors++;
      if ({imem_req, instr_valid, instr, pc, instr_count} !== {1'b0, 1'b0, 32'd0, RST_PC, 32'd0}) begin
         miscompares++;
         $display("FAIL rst_fetch_after got req=%b vld=%b instr=%h pc=%h cnt=%0d", imem_req, instr_valid, instr, pc, instr_count);
      end
      cycle();
      expPc = RST_PC; expPcW = RST_PCW; expCount = 32'd0;
   endtask

   task automatic test_jump();
      do_instr(0, $urandom, 0, 1'b0, 1'b0, 1'b0);
      do_instr(0, $urandom, 0, 1'b0, 1'b0, 1'b0);
      do_instr(2, {6'h02, 26'h100}, 0, 1'b1, 1'b1, 1'b1);
      vectors++;
      if (imem_addr !== 32'h4000_0400) begin
         miscompares++;
         $display("FAIL jump_target got %h exp 40000400", imem_addr);
      end
   endtask

   task automatic test_stall();
      do_instr(1, $urandom, 3, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (instr_count !== 32'd4) begin
         miscompares++;
         $display("FAIL stall_count got %0d exp 4", instr_count);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++) begin
         do_instr(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 2)),
                  1'($urandom), 1'($urandom), 1'($urandom));
      end
      vectors++;
      if ({instr_count, imem_addr} !== {expCount, expPc}) begin
         miscompares++;
         $display("FAIL random_end got cnt=%0d addr=%h exp cnt=%0d addr=%h", instr_count, imem_addr, expCount, expPc);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_sequential();
      test_latency();
      test_branch();
      test_reset_mid();
      test_jump();
      test_stall();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
